// File: rtl/aes_enc_ctrl.sv
// aes_enc_ctrl
//   Round sequencer for the aes_enc datapath. Registers a plaintext/key pair
//   taken on a valid/ready handshake, steps aes_enc through the initial,
//   middle and final rounds, and holds the finished cipher on a valid/ready
//   output handshake.
//
// Parameters
//   NR            number of rounds: 10, 12 or 14 (AES-128/192/256 schedules)
//
// Ports
//   clk           clock, all state on rising edge
//   rst           asynchronous active-high reset
//   in_valid_i    plaintext/key pair offered
//   in_ready_o    block can accept a pair (IDLE only)
//   plain_text_i  plaintext in
//   key_i         cipher key in
//   plain_text_o  registered plaintext -> aes_enc plain_text_i
//   key_o         registered key -> aes_enc key_i
//   en_rnd_o      -> aes_enc en_rnd_i
//   full_enc_o    -> aes_enc full_enc_i (select plaintext)
//   zero_rnd_o    -> aes_enc zero_rnd_i (1 = apply key, 0 = add zero)
//   final_rnd_o   -> aes_enc final_rnd_i (bypass mixcolumns)
//   key_sel_o     -> aes_enc key_sel_i (1 = key_o, 0 = round key)
//   rnd_idx_o     round-key index to the key store
//   out_valid_o   aes_enc cipher_o holds the final cipher
//   out_ready_i   downstream accepts the cipher
//   busy_o        sequencer is not idle
module aes_enc_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] plain_text_i,
  input  logic [127:0] key_i,
  output logic [127:0] plain_text_o,
  output logic [127:0] key_o,
  output logic         en_rnd_o,
  output logic         full_enc_o,
  output logic         zero_rnd_o,
  output logic         final_rnd_o,
  output logic         key_sel_o,
  output logic [3:0]   rnd_idx_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic         busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    RUN,
    DONE
  } state_t;

  localparam logic [3:0] LAST_RND = 4'(NR);

  state_t     state;
  state_t     state_next;
  logic [3:0] round;
  logic [3:0] round_next;
  logic       phase;
  logic       phase_next;
  logic       accept;

  // A pair is taken only while idle; in_valid_i is ignored otherwise.
  always_comb begin
    accept = (state == IDLE) && in_valid_i;
  end

  // State, round counter and phase registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      round <= '0;
      phase <= 1'b0;
    end else begin
      state <= state_next;
      round <= round_next;
      phase <= phase_next;
    end
  end

  // Holding registers for the operands feeding aes_enc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      plain_text_o <= '0;
      key_o        <= '0;
    end else if (accept) begin
      plain_text_o <= plain_text_i;
      key_o        <= key_i;
    end
  end

  // Next-state logic. Each middle/final round spans a fill cycle (phase 0)
  // and a commit cycle (phase 1) because the aes_enc loop is two registers
  // deep; the round counter only advances after a commit.
  always_comb begin
    state_next = state;
    round_next = round;
    phase_next = phase;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next = INIT;
        end
      end
      INIT: begin
        state_next = RUN;
        round_next = 4'd1;
        phase_next = 1'b0;
      end
      RUN: begin
        phase_next = ~phase;
        if (phase) begin
          if (round == LAST_RND) begin
            state_next = DONE;
          end else begin
            round_next = round + 4'd1;
          end
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_next = IDLE;
          round_next = '0;
          phase_next = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        round_next = '0;
        phase_next = 1'b0;
      end
    endcase
  end

  // Moore output decode from registered state, round and phase.
  always_comb begin
    in_ready_o  = 1'b0;
    busy_o      = 1'b1;
    en_rnd_o    = 1'b0;
    full_enc_o  = 1'b0;
    zero_rnd_o  = 1'b0;
    final_rnd_o = 1'b0;
    key_sel_o   = 1'b0;
    rnd_idx_o   = '0;
    out_valid_o = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b0;
      end
      INIT: begin
        // Initial AddRoundKey: aes_enc captures plaintext ^ key directly.
        en_rnd_o    = 1'b1;
        full_enc_o  = 1'b1;
        zero_rnd_o  = 1'b1;
        final_rnd_o = 1'b1;
        key_sel_o   = 1'b1;
      end
      RUN: begin
        en_rnd_o    = 1'b1;
        zero_rnd_o  = phase;
        final_rnd_o = phase && (round == LAST_RND);
        rnd_idx_o   = round;
      end
      DONE: begin
        // en_rnd_o stays low so aes_enc holds the cipher.
        out_valid_o = 1'b1;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

endmodule
